logic_pipe: RTL and testbench

- Parametrised, pipelined successor to the four-input combinational logic cell: `WIDTH`-bit bitwise vectors and four selectable logic modes.
- Two-stage valid/ready pipeline with backpressure, plus a wrapping count of completed results.
- Sits between operand registers and the result consumer in the lab datapath.
- Mode 0 reproduces the original cell's function bitwise.

---
 rtl/logic_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_logic_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe.sv
// -----------------------------------------------------------------------------
// logic_pipe
//
// Two-stage valid/ready pipeline that applies one of four bitwise logic
// functions to WIDTH-bit operands A/B/C/D and produces results E/F. It also
// keeps a wrapping count of results accepted by the consumer.
//
// Stage 1 captures the operand set together with its mode. Stage 2 turns the
// captured terms into E/F and presents them to the consumer.
//
// Modes:
//   0 : F = ~((A&B)|C) | (C&D)   E = C&D   (original four-input cell)
//   1 : F = A^B                  E = C^D
//   2 : F = A&B                  E = C|D
//   3 : F = ~(A|B)               E = ~(C&D)
//
// Optional build macro:
//   LOGIC_PIPE_ZERO_FLAG_EN - adds out_zero. It is registered with E/F and is
//                             1 when both E and F are zero.
//
// Parameters:
//   WIDTH     operand/result width
//   COUNT_W   width of the completed-result counter
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   operand set is valid
//   in_ready   out  pipeline accepts an operand set this cycle
//   mode       in   logic function select, captured with the operands
//   A,B,C,D    in   operands
//   out_valid  out  E/F hold a valid result
//   out_ready  in   consumer takes the result this cycle
//   E,F        out  results
//   out_count  out  results consumed, modulo 2**COUNT_W
//   out_zero   out  (optional) E == 0 and F == 0
// -----------------------------------------------------------------------------
module logic_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  input  logic [WIDTH-1:0]   D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   E,
  output logic [WIDTH-1:0]   F,
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  output logic               out_zero,
`endif
  output logic [COUNT_W-1:0] out_count
);

  // Mode-dependent A/B term carried through stage 1. Modes 1 and 3 need a
  // term that cannot be rebuilt from A&B alone. Modes 0 and 2 ignore it.
  function automatic logic [WIDTH-1:0] calc_term(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] t;
    t = (m == 2'd1) ? (a ^ b) : (a | b);
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] calc_f(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] ab,
    input logic [WIDTH-1:0] t,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] cd
  );
    logic [WIDTH-1:0] f;
    case (m)
      2'd0:    f = ~(ab | c) | cd;
      2'd1:    f = t;
      2'd2:    f = ab;
      default: f = ~t;
    endcase
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] calc_e(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] cd
  );
    logic [WIDTH-1:0] e;
    case (m)
      2'd0:    e = cd;
      2'd1:    e = c ^ d;
      2'd2:    e = c | d;
      default: e = ~cd;
    endcase
    return e;
  endfunction

  // Pipeline control
  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  // Stage 1 registers
  logic             vld_p1_q,  vld_p1_d;
  logic [1:0]       mode_p1_q, mode_p1_d;
  logic [WIDTH-1:0] c_p1_q,    c_p1_d;
  logic [WIDTH-1:0] d_p1_q,    d_p1_d;
  logic [WIDTH-1:0] ab_p1_q,   ab_p1_d;
  logic [WIDTH-1:0] cd_p1_q,   cd_p1_d;
  logic [WIDTH-1:0] t_p1_q,    t_p1_d;

  // Stage 2 registers
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] e_p2_q,   e_p2_d;
  logic [WIDTH-1:0] f_p2_q,   f_p2_d;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  logic             z_p2_q,   z_p2_d;
`endif

  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // Stage 2 may load when it is empty or its result leaves this cycle.
  // Stage 1 may then accept new data even while full, because its current
  // contents move into stage 2 on the same edge.
  always_comb begin
    s2_adv   = ~vld_p2_q | out_ready;
    s1_adv   = vld_p1_q & s2_adv;
    in_ready = ~vld_p1_q | s2_adv;
    in_fire  = in_valid & in_ready;
    out_fire = vld_p2_q & out_ready;
  end

  // ---- stage 0 -> stage 1 : operand capture ----
  always_comb begin
    vld_p1_d  = vld_p1_q;
    mode_p1_d = mode_p1_q;
    c_p1_d    = c_p1_q;
    d_p1_d    = d_p1_q;
    ab_p1_d   = ab_p1_q;
    cd_p1_d   = cd_p1_q;
    t_p1_d    = t_p1_q;
    if (in_fire) begin
      vld_p1_d  = 1'b1;
      mode_p1_d = mode;
      c_p1_d    = C;
      d_p1_d    = D;
      ab_p1_d   = A & B;
      cd_p1_d   = C & D;
      t_p1_d    = calc_term(mode, A, B);
    end else if (s1_adv) begin
      vld_p1_d  = 1'b0;
    end
  end

  // ---- stage 1 -> stage 2 : result ----
  always_comb begin
    vld_p2_d = vld_p2_q;
    e_p2_d   = e_p2_q;
    f_p2_d   = f_p2_q;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    z_p2_d   = z_p2_q;
`endif
    if (s2_adv) begin
      vld_p2_d = vld_p1_q;
    end
    // E/F keep their old value when stage 2 drains into an empty stage 1.
    if (s1_adv) begin
      e_p2_d = calc_e(mode_p1_q, c_p1_q, d_p1_q, cd_p1_q);
      f_p2_d = calc_f(mode_p1_q, ab_p1_q, t_p1_q, c_p1_q, cd_p1_q);
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      z_p2_d = (e_p2_d == '0) && (f_p2_d == '0);
`endif
    end
    cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, out_fire};
  end

  // Control state and visible outputs are reset. The stage 1 payload is
  // qualified by vld_p1_q, so it is left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      e_p2_q   <= '0;
      f_p2_q   <= '0;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      z_p2_q   <= 1'b0;
`endif
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      e_p2_q   <= e_p2_d;
      f_p2_q   <= f_p2_d;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      z_p2_q   <= z_p2_d;
`endif
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_p1_q <= mode_p1_d;
    c_p1_q    <= c_p1_d;
    d_p1_q    <= d_p1_d;
    ab_p1_q   <= ab_p1_d;
    cd_p1_q   <= cd_p1_d;
    t_p1_q    <= t_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign E         = e_p2_q;
  assign F         = f_p2_q;
  assign out_count = cnt_q;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  assign out_zero  = z_p2_q;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Testbench for logic_pipe with WIDTH=4 and COUNT_W=2.
// The reference model is a queue of expected results with their capture cycle.
// A result becomes visible two cycles after capture when it heads the queue.
// in_ready is expected to be high unless two sets are in flight and the
// consumer is stalling.
module tb_logic_pipe;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [W-1:0]  A, B, C, D;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  E, F;
  logic [CW-1:0] out_count;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
  logic          out_zero;
`endif

  logic_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .A(A), .B(B), .C(C), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .E(E), .F(F),
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    .out_zero(out_zero),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] e, f;
    logic         z;
    int           cyc;
  } item_t;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] a, b, c, d;
    logic [W-1:0] f, e;
    logic         z;
  } vec_t;

  item_t         q[$];
  int            ncyc;
  logic [CW-1:0] cnt_m;
  int            tests, fails;
  vec_t          vec[6];
  int            exp_cnt[8];

  function automatic void ref_ef(input logic [1:0] m, input logic [W-1:0] a, b, c, d,
                                 output logic [W-1:0] e, output logic [W-1:0] f);
    case (m)
      2'd0: begin f = ~((a & b) | c) | (c & d); e = c & d; end
      2'd1: begin f = a ^ b; e = c ^ d; end
      2'd2: begin f = a & b; e = c | d; end
      default: begin f = ~(a | b); e = ~(c & d); end
    endcase
  endfunction

  function automatic bit ov_exp();
    return (q.size() > 0) && (q[0].cyc + 2 <= ncyc);
  endfunction

  function automatic bit ir_exp();
    return (q.size() < 2) || (out_ready == 1'b1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc_begin(input bit iv, input logic [1:0] m, input logic [W-1:0] a, b, c, d,
                           input bit ordy);
    in_valid = iv; mode = m; A = a; B = b; C = c; D = d; out_ready = ordy;
    #1;
    check("out_valid", out_valid, ov_exp());
    check("in_ready", in_ready, ir_exp());
    check("out_count", out_count, cnt_m);
    if (ov_exp()) begin
      check("E", E, q[0].e);
      check("F", F, q[0].f);
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
      check("out_zero", out_zero, q[0].z);
`endif
    end
  endtask

  task automatic cyc_end();
    item_t it;
    bit    ho, hi;
    ho = ov_exp() && out_ready;
    hi = in_valid && ir_exp();
    if (ho) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (hi) begin
      ref_ef(mode, A, B, C, D, it.e, it.f);
      it.z   = (it.e == '0) && (it.f == '0);
      it.cyc = ncyc;
      q.push_back(it);
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    cnt_m = '0;
    ncyc++;
    check("rst_out_valid", out_valid, 0);
    check("rst_E", E, 0);
    check("rst_F", F, 0);
    check("rst_count", out_count, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    check("rst_out_zero", out_zero, 0);
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sf, se;
    int           seen;
    bit           pend;

    vec[0] = '{2'd0, 4'b1100, 4'b1010, 4'b0110, 4'b0011, 4'b0011, 4'b0010, 1'b0};
    vec[1] = '{2'd1, 4'b1100, 4'b1010, 4'b0110, 4'b0011, 4'b0110, 4'b0101, 1'b0};
    vec[2] = '{2'd2, 4'b1100, 4'b1010, 4'b0110, 4'b0011, 4'b1000, 4'b0111, 1'b0};
    vec[3] = '{2'd3, 4'b1100, 4'b1010, 4'b0110, 4'b0011, 4'b0001, 4'b1101, 1'b0};
    vec[4] = '{2'd2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vec[5] = '{2'd2, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    exp_cnt = '{0, 0, 0, 1, 2, 3, 0, 1};

    tests = 0; fails = 0; ncyc = 0; cnt_m = '0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = '0;
    A = '0; B = '0; C = '0; D = '0;
    @(posedge clk);
    do_reset();

    // Directed vectors, back to back
    for (int i = 0; i < 8; i++) begin
      if (i < 6) cyc_begin(1'b1, vec[i].m, vec[i].a, vec[i].b, vec[i].c, vec[i].d, 1'b1);
      else       cyc_begin(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      if (i < 6) check("tbl_in_ready", in_ready, 1);
      if (i >= 2) begin
        check("tbl_out_valid", out_valid, 1);
        check("tbl_F", F, vec[i-2].f);
        check("tbl_E", E, vec[i-2].e);
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
        check("tbl_zero", out_zero, vec[i-2].z);
`endif
      end
      cyc_end();
    end

    // Counter wrap with COUNT_W=2
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc_begin(k < 5, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                W'($urandom), W'($urandom), 1'b1);
      check("cnt_seq", out_count, exp_cnt[k]);
      cyc_end();
    end

    // Stall: three sets while the consumer holds off
    do_reset();
    ref_ef(2'd1, 4'b0011, 4'b0101, 4'b1001, 4'b0110, se, sf);
    cyc_begin(1'b1, 2'd1, 4'b0011, 4'b0101, 4'b1001, 4'b0110, 1'b0); cyc_end();
    cyc_begin(1'b1, 2'd2, 4'b1111, 4'b0110, 4'b0001, 4'b1000, 1'b0); cyc_end();
    for (int k = 0; k < 3; k++) begin
      cyc_begin(1'b1, 2'd3, 4'b0100, 4'b0010, 4'b1110, 4'b0111, 1'b0);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_F", F, sf);
      check("stall_E", E, se);
      cyc_end();
    end
    pend = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      // mode changes on idle cycles must not disturb captured sets
      cyc_begin(pend, pend ? 2'd3 : 2'd0, 4'b0100, 4'b0010, 4'b1110, 4'b0111, 1'b1);
      if (out_valid) seen++;
      if (pend && ir_exp()) pend = 1'b0;
      cyc_end();
    end
    check("stall_drain_count", seen, 3);

    // Reset with both stages full
    cyc_begin(1'b1, 2'd0, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0); cyc_end();
    cyc_begin(1'b1, 2'd1, 4'b1010, 4'b0101, 4'b1100, 4'b0011, 1'b0); cyc_end();
    do_reset();
    cyc_begin(1'b1, vec[0].m, vec[0].a, vec[0].b, vec[0].c, vec[0].d, 1'b1); cyc_end();
    cyc_begin(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1); cyc_end();
    cyc_begin(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_F", F, 4'b0011);
    check("post_rst_E", E, 4'b0010);
    cyc_end();
    cyc_begin(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("post_rst_count", out_count, 1);
    cyc_end();

    // Randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cyc_begin(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
                  W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
        cyc_end();
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc_begin(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      cyc_end();
    end
    check("final_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
